// File: rtl/pipe_sched.sv
// pipe_sched: round-robin issue scheduler in front of a shared pipeline.
// Up to DEPTH transactions may be in flight. A tag FIFO remembers the
// owner of each one so that completions return to the right requester.
// Optional feature macro: PIPE_SCHED_STATS_EN adds a saturating 16-bit
// issue counter on port issue_cnt.
module pipe_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [DATA_WIDTH-1:0]         pipe_data,
    output logic                          pipe_valid,
    input  logic                          pipe_hold,
    input  logic                          pipe_done,
    output logic [NUM_REQ-1:0]            done,
    input  logic                          flush,
    output logic                          busy
`ifdef PIPE_SCHED_STATS_EN
    ,
    output logic [15:0]                   issue_cnt
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // FIFO pointer advance with wrap at DEPTH (DEPTH need not be a power of 2).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : (p + PW'(1));
    endfunction

    state_t              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]       tag_mem_q [DEPTH];
    logic [NUM_REQ-1:0]  done_q, done_d;

    logic                issue_s;
    logic                pop_s;
    logic                hi_found_s;
    logic [IW-1:0]       hi_idx_s;
    logic [IW-1:0]       lo_idx_s;
    logic [IW-1:0]       win_idx_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [DATA_WIDTH-1:0] pipe_data_s;
    logic [IW-1:0]       head_tag_s;

    // Round-robin search: lowest requester above the pointer, else lowest overall.
    always_comb begin
        hi_found_s = 1'b0;
        hi_idx_s   = {IW{1'b0}};
        lo_idx_s   = {IW{1'b0}};
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            lo_idx_s   = req[j] ? IW'(j) : lo_idx_s;
            hi_idx_s   = (req[j] && (IW'(j) > rr_ptr_q)) ? IW'(j) : hi_idx_s;
            hi_found_s = hi_found_s | (req[j] && (IW'(j) > rr_ptr_q));
        end
        win_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Issue qualification plus grant and data mux; reset suppresses any issue.
    always_comb begin
        issue_s     = (!rst) && (state_q == ST_ISSUE) && (|req) && (!pipe_hold)
                      && (count_q < CW'(DEPTH));
        gnt_s       = {NUM_REQ{1'b0}};
        pipe_data_s = {DATA_WIDTH{1'b0}};
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt_s[j]    = issue_s && (win_idx_s == IW'(j));
            pipe_data_s = pipe_data_s
                          | (req_data[j*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_s[j]}});
        end
    end

    // Completion bookkeeping: ignore pipe_done with nothing in flight.
    always_comb begin
        pop_s      = pipe_done && (count_q != {CW{1'b0}});
        head_tag_s = tag_mem_q[rd_ptr_q];
        done_d     = {NUM_REQ{1'b0}};
        for (int j = 0; j < NUM_REQ; j++) begin
            done_d[j] = pop_s && (head_tag_s == IW'(j));
        end
        count_d  = count_q + CW'(issue_s) - CW'(pop_s);
        wr_ptr_d = issue_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        rr_ptr_d = issue_s ? win_idx_s : rr_ptr_q;
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (|req) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (req == {NUM_REQ{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (count_q == {CW{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= IW'(NUM_REQ - 1);
            count_q  <= {CW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            done_q   <= {NUM_REQ{1'b0}};
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= done_d;
        end
    end

    // Tag FIFO storage: the winner index is written on each issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i] <= {IW{1'b0}};
            end
        end else if (issue_s) begin
            tag_mem_q[wr_ptr_q] <= win_idx_s;
        end
    end

    assign gnt        = gnt_s;
    assign pipe_data  = pipe_data_s;
    assign pipe_valid = issue_s;
    assign done       = done_q;
    assign busy       = (count_q != {CW{1'b0}}) || (state_q != ST_IDLE);

`ifdef PIPE_SCHED_STATS_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;

    // Saturating issue counter.
    always_comb begin
        if (issue_s && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end else begin
            issue_cnt_d = issue_cnt_q;
        end
    end

    // Issue counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= 16'd0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
`endif

endmodule
